// File: rtl/registro_pkg.sv
// registro_pkg: shared definitions for the VGA time/date register bank.
//   - field index constants (sec, min, hour, day, month, year)
//   - action type decoded each cycle by the bank
//   - per-field BCD limits and a BCD digit validity check
package registro_pkg;

    localparam int unsigned CAMPO_SEG  = 0;
    localparam int unsigned CAMPO_MIN  = 1;
    localparam int unsigned CAMPO_HORA = 2;
    localparam int unsigned CAMPO_DIA  = 3;
    localparam int unsigned CAMPO_MES  = 4;
    localparam int unsigned CAMPO_ANO  = 5;

    typedef enum logic [1:0] {
        ACC_NINGUNA,
        ACC_CAPTURA,
        ACC_ESCRITURA,
        ACC_PASO
    } accion_t;

    // Smallest legal BCD value for a field; indices past the year behave like the year.
    function automatic logic [7:0] campo_min(input int unsigned idx);
        case (idx)
            CAMPO_DIA, CAMPO_MES: return 8'h01;
            default:              return 8'h00;
        endcase
    endfunction

    // Largest legal BCD value for a field.
    function automatic logic [7:0] campo_max(input int unsigned idx);
        case (idx)
            CAMPO_SEG, CAMPO_MIN: return 8'h59;
            CAMPO_HORA:           return 8'h23;
            CAMPO_DIA:            return 8'h31;
            CAMPO_MES:            return 8'h12;
            default:              return 8'h99;
        endcase
    endfunction

    function automatic logic bcd_valido(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_paso.sv
// bcd_paso: combinational two-digit BCD increment/decrement with wrap.
//   valor     current field value
//   vmin/vmax legal range of the field
//   subir     1 = +1, 0 = -1
//   siguiente stepped value (vmin when valor is not BCD)
//   invalido  1 when valor is not a valid BCD pair
module bcd_paso
    import registro_pkg::*;
(
    input  logic [7:0] valor,
    input  logic [7:0] vmin,
    input  logic [7:0] vmax,
    input  logic       subir,
    output logic [7:0] siguiente,
    output logic       invalido
);

    always_comb begin
        siguiente = vmin;
        invalido  = 1'b0;
        if (!bcd_valido(valor)) begin
            invalido = 1'b1;
        end else if (subir) begin
            if (valor >= vmax)
                siguiente = vmin;
            else if (valor[3:0] == 4'd9)
                siguiente = {valor[7:4] + 4'd1, 4'd0};
            else
                siguiente = {valor[7:4], valor[3:0] + 4'd1};
        end else begin
            if (valor <= vmin)
                siguiente = vmax;
            else if (valor[3:0] == 4'd0)
                siguiente = {valor[7:4] - 4'd1, 4'd9};
            else
                siguiente = {valor[7:4], valor[3:0] - 4'd1};
        end
    end

endmodule

// File: rtl/registro_banco_vga.sv
// registro_banco_vga: bank of BCD time/date fields feeding the VGA text renderer.
//   clk, reset(active-low, async)
//   seleccion   1 = RTC capture source, 0 = user edit source
//   EN_deco     global enable for load/step/commit
//   EN / ACT    edit write strobe / RTC capture strobe
//   addr, dseg  target field index and BCD data
//   inc, dec    edit step on field addr
//   commit      request write-back toward the RTC write FSM
//   dato_bus    all fields, field i at [i*W +: W] (registered)
//   dirty       per-field edited flag
//   commit_req  one-cycle pulse; commit_mask holds the dirty snapshot
//   err         one-cycle pulse on a rejected action
//   blink_mask  1 = render field, 0 = blank (edited field blinks)
module registro_banco_vga
    import registro_pkg::*;
#(
    parameter  int unsigned N_CAMPOS  = 6,
    parameter  int unsigned W         = 8,
    parameter  int unsigned BLINK_DIV = 25_000_000,
    localparam int unsigned AW        = $clog2(N_CAMPOS)
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  seleccion,
    input  logic                  EN_deco,
    input  logic                  EN,
    input  logic                  ACT,
    input  logic [AW-1:0]         addr,
    input  logic [W-1:0]          dseg,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  commit,
    output logic [N_CAMPOS*W-1:0] dato_bus,
    output logic [N_CAMPOS-1:0]   dirty,
    output logic                  commit_req,
    output logic [N_CAMPOS-1:0]   commit_mask,
    output logic                  err,
    output logic [N_CAMPOS-1:0]   blink_mask
);

    localparam int unsigned CW   = $clog2(BLINK_DIV);
    localparam logic [AW:0] NLIM = (AW+1)'(N_CAMPOS);
    localparam logic [CW-1:0] TC = CW'(BLINK_DIV - 1);

    logic [W-1:0]        campo [N_CAMPOS];
    logic [W-1:0]        cur;
    logic                addr_ok;
    logic [7:0]          vmin, vmax;
    logic [7:0]          paso_sig;
    logic                paso_inv;
    logic                acepta;
    accion_t             accion;
    logic                commit_go;

    logic                escribir;
    logic [W-1:0]        valor_nuevo;
    logic                err_d;
    logic                marca;
    logic                limpia;
    logic                reinicia;
    logic [N_CAMPOS-1:0] dirty_mod;

    logic [CW-1:0]       cnt;
    logic                fase;

    assign addr_ok = {1'b0, addr} < NLIM;
    assign vmin    = campo_min(32'(addr));
    assign vmax    = campo_max(32'(addr));
    assign acepta  = bcd_valido(8'(dseg)) && (8'(dseg) >= vmin) && (8'(dseg) <= vmax);

    always_comb begin
        cur = '0;
        if (addr_ok)
            cur = campo[addr];
    end

    bcd_paso u_paso (
        .valor     (8'(cur)),
        .vmin      (vmin),
        .vmax      (vmax),
        .subir     (inc),
        .siguiente (paso_sig),
        .invalido  (paso_inv)
    );

    // Capture beats edit write beats step; inc together with dec is no action.
    always_comb begin
        accion = ACC_NINGUNA;
        if (EN_deco) begin
            if (seleccion && ACT)
                accion = ACC_CAPTURA;
            else if (!seleccion && EN)
                accion = ACC_ESCRITURA;
            else if (!seleccion && (inc ^ dec))
                accion = ACC_PASO;
        end
    end

    assign commit_go = EN_deco && !seleccion && commit;

    always_comb begin
        escribir    = 1'b0;
        valor_nuevo = '0;
        err_d       = 1'b0;
        marca       = 1'b0;
        limpia      = 1'b0;
        reinicia    = 1'b0;
        case (accion)
            ACC_CAPTURA: begin
                if (addr_ok) begin
                    escribir    = 1'b1;
                    valor_nuevo = dseg;
                    limpia      = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            ACC_ESCRITURA: begin
                if (addr_ok && acepta) begin
                    escribir    = 1'b1;
                    valor_nuevo = dseg;
                    marca       = 1'b1;
                    reinicia    = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            ACC_PASO: begin
                if (addr_ok) begin
                    escribir    = 1'b1;
                    valor_nuevo = W'(paso_sig);
                    marca       = 1'b1;
                    reinicia    = 1'b1;
                    err_d       = paso_inv;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Dirty vector including this cycle's edit, so a same-cycle commit sees it.
    always_comb begin
        dirty_mod = dirty;
        if (marca)
            dirty_mod[addr] = 1'b1;
        if (limpia)
            dirty_mod[addr] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_CAMPOS; i++)
                campo[i] <= W'(campo_min(i));
            dirty       <= '0;
            commit_req  <= 1'b0;
            commit_mask <= '0;
            err         <= 1'b0;
        end else begin
            if (escribir)
                campo[addr] <= valor_nuevo;
            err        <= err_d;
            commit_req <= commit_go;
            if (commit_go) begin
                commit_mask <= dirty_mod;
                dirty       <= '0;
            end else begin
                dirty <= dirty_mod;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            fase <= 1'b1;
        end else if (seleccion || reinicia) begin
            cnt  <= '0;
            fase <= 1'b1;
        end else if (cnt == TC) begin
            cnt  <= '0;
            fase <= ~fase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        blink_mask = '1;
        if (!seleccion && addr_ok)
            blink_mask[addr] = fase;
    end

    always_comb begin
        dato_bus = '0;
        for (int unsigned i = 0; i < N_CAMPOS; i++)
            dato_bus[i*W +: W] = campo[i];
    end

endmodule
